// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer for a TTL frequency meter: conditions the input, times
// the gate for the selected range and strobes clear/count/latch to the decade chain.
module freq_gate_ctrl #(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned GATE_W       = 32
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       run,
  input  logic [1:0] range_sel,
  input  logic       sig_in,
  input  logic       carry_top,
  output logic       cnt_clear,
  output logic       cnt_en,
  output logic       latch,
  output logic       overflow,
  output logic [1:0] range_act,
  output logic       busy
);

  localparam int unsigned G_R0 = TICKS_PER_MS * 10;
  localparam int unsigned G_R1 = TICKS_PER_MS * 100;
  localparam int unsigned G_R2 = TICKS_PER_MS * 1000;
  localparam int unsigned G_R3 = TICKS_PER_MS * 10000;

  localparam logic [GATE_W-1:0] LOAD_R0 = GATE_W'(G_R0 - 1);
  localparam logic [GATE_W-1:0] LOAD_R1 = GATE_W'(G_R1 - 1);
  localparam logic [GATE_W-1:0] LOAD_R2 = GATE_W'(G_R2 - 1);
  localparam logic [GATE_W-1:0] LOAD_R3 = GATE_W'(G_R3 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [1:0]        range_q, range_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic              overflow_q, overflow_d;
  logic              s1_q, s2_q, s3_q;
  logic              sig_edge_c;
  logic [GATE_W-1:0] gate_load_c;

  // s1/s2 form the synchroniser, s3 is the history flop for edge detection
  assign sig_edge_c = s2_q & ~s3_q;

  always_comb begin
    gate_load_c = LOAD_R0;
    case (range_sel)
      2'd0:    gate_load_c = LOAD_R0;
      2'd1:    gate_load_c = LOAD_R1;
      2'd2:    gate_load_c = LOAD_R2;
      default: gate_load_c = LOAD_R3;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      range_q    <= '0;
      ovf_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      range_q    <= range_d;
      ovf_acc_q  <= ovf_acc_d;
      overflow_q <= overflow_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    range_d    = range_q;
    ovf_acc_d  = ovf_acc_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        range_d    = range_sel;
        gate_cnt_d = gate_load_c;
        ovf_acc_d  = 1'b0;
        state_d    = S_GATE;
      end
      S_GATE: begin
        if (carry_top) ovf_acc_d = 1'b1;
        if (gate_cnt_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      S_SETTLE: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        overflow_d = ovf_acc_q;
        state_d    = run ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register; cnt_en also gates on the flop-derived edge
  assign cnt_clear = (state_q == S_CLEAR);
  assign cnt_en    = (state_q == S_GATE) & sig_edge_c;
  assign latch     = (state_q == S_LATCH);
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;
  assign range_act = range_q;

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the TTL frequency meter. It sits in front of the cascaded BCD decade counter chain, which runs on the system clock. It synchronises the external TTL input and turns its rising edges into one-cycle count pulses. It opens a gate window of exact length, chosen from four ranges, and then issues clear, count-enable and latch strobes to the decade chain and the display registers, repeating while `run` is high.

## Interface
- `TICKS_PER_MS`, default 50000: `clock` cycles per millisecond (50 MHz system clock).
- `GATE_W`, default 32: width of the gate-length down-counter. It must hold `TICKS_PER_MS*10000`.
- `clock` in 1: system clock. All logic is on the rising edge.
- `clear_n` in 1: reset. Synchronous, active-low.
- `run` in 1: level. While high, measurements repeat back-to-back. While low, the block stops after the current measurement.
- `range_sel` in 2: gate length. 0 = 10 ms, 1 = 100 ms, 2 = 1 s, 3 = 10 s.
- `sig_in` in 1: asynchronous TTL input under measurement.
- `carry_top` in 1: `c_out` of the most-significant decade.
- `cnt_clear` out 1: clear strobe to every decade.
- `cnt_en` out 1: `c_in` of the least-significant decade. It is one cycle per qualified input edge.
- `latch` out 1: one-cycle strobe. The display registers capture the BCD digits on it.
- `overflow` out 1: the last completed measurement exceeded the counter chain.
- `range_act` out 2: range used by the measurement in progress or last completed.
- `busy` out 1: high in every state except IDLE.

## Operation
- Input conditioning:
  - `sig_in` passes through a 2-flop synchroniser (`s1`, `s2`), then a history flop `s3`.
  - `edge = s2 & ~s3`.
  - All three flops reset to 0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE:
  - If `run` = 1, go to CLEAR; otherwise stay in IDLE.
  - Outputs `cnt_clear`, `cnt_en` and `latch` are 0.
- CLEAR (1 cycle):
  - `cnt_clear` = 1.
  - Sample `range_sel` into `range_act`.
  - Load the gate counter with G−1, where G = `TICKS_PER_MS` × {10, 100, 1000, 10000}[`range_sel`].
  - Clear the internal overflow flag `ovf_acc`.
  - Next state is GATE.
- GATE (exactly G cycles):
  - `cnt_en = edge`.
  - The gate counter decrements each cycle; at 0, go to SETTLE.
  - `carry_top` = 1 in any GATE cycle sets sticky `ovf_acc`.
- SETTLE (1 cycle):
  - `cnt_en` = 0.
  - Lets the final count pulse land in the decade registers.
  - Next state is LATCH.
- LATCH (1 cycle):
  - `latch` = 1.
  - `overflow <= ovf_acc`.
  - Next state is CLEAR if `run` = 1, else IDLE.
- Gate-length arithmetic is unsigned. The G values are constants computed from `TICKS_PER_MS`; no runtime multiplier is used.
- Changes to `range_sel` outside a CLEAR cycle have no effect until the next CLEAR.
- Dropping `run` mid-measurement does not abort it. The measurement completes through LATCH, then the FSM enters IDLE.
- `carry_top` outside GATE is ignored.
- Reset:
  - `clear_n` = 0 on any clock edge forces IDLE.
  - The following all become 0: `cnt_clear`, `cnt_en`, `latch`, `overflow`, `range_act`, `busy`, `ovf_acc`, gate counter, `s1`, `s2`, `s3`.
  - Reset mid-GATE discards the measurement; no `latch` is issued.
- `cnt_en`, `cnt_clear`, `latch` and `busy` are decoded from registered state. `cnt_en` additionally ANDs with `edge`, which is flop-derived, so it has no combinational path from `sig_in`.

## Timing
- `run` sampled high in IDLE gives CLEAR on the next cycle. GATE starts 2 cycles after the sampling edge.
- Measurement period: G + 3 cycles (CLEAR + G × GATE + SETTLE + LATCH). Back-to-back measurements repeat with this period.
- Input latency: a rising edge of `sig_in` produces `edge` 2 to 3 cycles later. It is counted only if `edge` falls inside GATE.
- Maximum countable input frequency: `clock`/2. A high or low phase shorter than one `clock` period may be missed.
- An edge straddling a gate boundary is counted in at most one measurement, never two.
- `overflow` and the latched digits change together, on the cycle after `latch`. `overflow` holds until the next LATCH or reset.
- `range_act` is valid from the cycle after CLEAR.

## Test plan
- **Reset mid-GATE.**
  - Stimulus: `TICKS_PER_MS`=4, `range_sel`=0, `run`=1, `sig_in` period 4 cycles.
  - Response: one `cnt_clear` pulse, then exactly 40 GATE cycles with exactly 10 `cnt_en` pulses. `latch` is seen 42 cycles after `cnt_clear`.
  - Stimulus, continued: assert `clear_n`=0 at gate cycle 20.
  - Response: all outputs 0 next cycle, FSM in IDLE, no `latch`.
- **Range change mid-gate.**
  - Stimulus: `range_sel` changed from 1 to 3 during GATE.
  - Response: the current gate stays at 400 cycles and `range_act`=1. The next CLEAR samples 3, giving a 40000-cycle gate and `range_act`=3.
- **Overflow on one measurement only.**
  - Stimulus: force `carry_top`=1 for one GATE cycle of measurement k.
  - Response: `overflow`=1 after latch k; `overflow`=0 after latch k+1.
  - Stimulus: pulse `carry_top` during SETTLE only.
  - Response: `overflow` stays 0.
- **`run` dropped mid-gate.**
  - Stimulus: `run` goes 1→0 during GATE.
  - Response: that measurement completes with a `latch` pulse, then IDLE with `busy`=0. No further `cnt_clear` until `run` is 1 again.
- **Constant input.**
  - Stimulus: `sig_in` held at 1 for a full measurement, and separately held at 0.
  - Response: zero `cnt_en` pulses in both cases, apart from at most the single post-reset edge in the first 3 cycles.
- **Maximum-rate input.**
  - Stimulus: `sig_in` toggling every cycle (`clock`/2), `range_sel`=0, `TICKS_PER_MS`=4.
  - Response: exactly 20 `cnt_en` pulses per 40-cycle gate.
